// File: rtl/vdp18_spr_sched.sv
// Sprite access-slot scheduler: issues STST test slots interleaved with CPU slots during the
// active line, then the per-sprite SATY..SPTL read burst, yielding to the background fetcher.
module vdp18_spr_sched #(
  parameter int unsigned ACTIVE_LINES    = 192,
  parameter int unsigned MAX_TESTS       = 32,
  parameter int unsigned MAX_SPR         = 4,
  parameter int unsigned HV_SPRITE_START = 247
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clk_en_5m37_i,
  input  logic       clk_en_acc_i,
  input  logic [8:0] num_pix_i,
  input  logic [8:0] num_line_i,
  input  logic       vert_inc_i,
  input  logic       reg_blank_i,
  input  logic       reg_size1_i,
  input  logic       bg_slot_i,
  input  logic       stop_sprite_i,
  input  logic       cpu_req_i,
  output logic [3:0] access_type_o,
  output logic       cpu_ack_o,
  output logic [1:0] spr_phase_o
);

  localparam logic [3:0] AcNone = 4'd0;
  localparam logic [3:0] AcCpu  = 4'd1;
  localparam logic [3:0] AcStst = 4'd2;
  localparam logic [3:0] AcSaty = 4'd3;
  localparam logic [3:0] AcSpth = 4'd7;
  localparam logic [3:0] AcSptl = 4'd8;

  localparam logic [8:0] SprStart = 9'(HV_SPRITE_START);
  localparam logic [8:0] ActLines = 9'(ACTIVE_LINES);
  localparam logic [5:0] MaxTests = 6'(MAX_TESTS);
  localparam logic [2:0] MaxSpr   = 3'(MAX_SPR);

  typedef enum logic [1:0] {StIdle = 2'b00, StTest = 2'b01, StRead = 2'b10} phase_e;

  phase_e     phase_q, phase_d;
  logic [5:0] test_cnt_q, test_cnt_d;
  logic [2:0] spr_cnt_q, spr_cnt_d;
  logic       tst_spare_q, tst_spare_d;
  logic [2:0] rd_step_q, rd_step_d;
  logic       size1_q, size1_d;
  logic [3:0] access_q, access_d;
  logic       cpu_ack_q, cpu_ack_d;

  logic [3:0] cpu_slot;
  logic       line_active, test_trig, read_trig, last_pat;

  assign cpu_slot    = cpu_req_i ? AcCpu : AcNone;
  assign line_active = !num_line_i[8] && (num_line_i < ActLines);
  assign test_trig   = clk_en_5m37_i && (num_pix_i == 9'd0) && line_active && !reg_blank_i;
  assign read_trig   = clk_en_5m37_i && (num_pix_i == SprStart) && !stop_sprite_i && !reg_blank_i;
  assign last_pat    = (access_q == AcSptl) || ((access_q == AcSpth) && !size1_q);

  always_comb begin
    phase_d     = phase_q;
    test_cnt_d  = test_cnt_q;
    spr_cnt_d   = spr_cnt_q;
    tst_spare_d = tst_spare_q;
    rd_step_d   = rd_step_q;
    size1_d     = size1_q;
    access_d    = access_q;
    cpu_ack_d   = clk_en_acc_i && (access_q == AcCpu);

    // Retire the slot that ends on this strobe.
    if (clk_en_acc_i) begin
      case (phase_q)
        StTest: begin
          if (access_q == AcStst) begin
            if (test_cnt_q < MaxTests) test_cnt_d = test_cnt_q + 6'd1;
            if (stop_sprite_i || (test_cnt_d >= MaxTests)) phase_d = StIdle;
          end
        end
        StRead: begin
          if (last_pat) begin
            if (spr_cnt_q < MaxSpr) spr_cnt_d = spr_cnt_q + 3'd1;
            if (stop_sprite_i || (spr_cnt_d >= MaxSpr)) phase_d = StIdle;
          end
        end
        default: ;
      endcase
      if (reg_blank_i) phase_d = StIdle;
    end

    if (read_trig) begin
      phase_d   = StRead;
      spr_cnt_d = 3'd0;
      rd_step_d = 3'd0;
    end else if (test_trig) begin
      phase_d     = StTest;
      test_cnt_d  = 6'd0;
      tst_spare_d = 1'b0;
    end

    // Load the next slot; a yielded slot leaves the sequence pointers untouched.
    if (clk_en_acc_i) begin
      if (bg_slot_i) begin
        access_d = AcNone;
      end else begin
        case (phase_d)
          StTest: begin
            if (tst_spare_d) begin
              access_d    = cpu_slot;
              tst_spare_d = 1'b0;
            end else begin
              access_d    = AcStst;
              tst_spare_d = 1'b1;
            end
          end
          StRead: begin
            access_d = AcSaty + {1'b0, rd_step_d};
            case (rd_step_d)
              3'd4: begin
                size1_d   = reg_size1_i;
                rd_step_d = reg_size1_i ? 3'd5 : 3'd0;
              end
              3'd5:    rd_step_d = 3'd0;
              default: rd_step_d = rd_step_d + 3'd1;
            endcase
          end
          default: access_d = cpu_slot;
        endcase
      end
    end

    if (vert_inc_i) begin
      phase_d     = StIdle;
      test_cnt_d  = 6'd0;
      spr_cnt_d   = 3'd0;
      tst_spare_d = 1'b0;
      rd_step_d   = 3'd0;
      access_d    = AcNone;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      phase_q     <= StIdle;
      test_cnt_q  <= 6'd0;
      spr_cnt_q   <= 3'd0;
      tst_spare_q <= 1'b0;
      rd_step_q   <= 3'd0;
      size1_q     <= 1'b0;
      access_q    <= AcNone;
      cpu_ack_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      test_cnt_q  <= test_cnt_d;
      spr_cnt_q   <= spr_cnt_d;
      tst_spare_q <= tst_spare_d;
      rd_step_q   <= rd_step_d;
      size1_q     <= size1_d;
      access_q    <= access_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign access_type_o = access_q;
  assign cpu_ack_o     = cpu_ack_q;
  assign spr_phase_o   = phase_q;

endmodule

// File: tb/tb_vdp18_spr_sched.sv
// Bench for vdp18_spr_sched: builds the intended slot list per phase, splices in yielded
// slots and idle CPU slots, and compares every consumed slot, phase and ack count.
module tb_vdp18_spr_sched;
  localparam logic [3:0] NONE = 4'd0, CPU = 4'd1, STST = 4'd2, SATY = 4'd3, SATX = 4'd4;
  localparam logic [3:0] SATN = 4'd5, SATC = 4'd6, SPTH = 4'd7, SPTL = 4'd8;

  logic       clk = 1'b0, rst_n = 1'b0, en5 = 1'b0, acc = 1'b0, vert = 1'b0, blank = 1'b0;
  logic       size1 = 1'b0, bg = 1'b0, stop = 1'b0, req = 1'b0;
  logic [8:0] pix = 9'd100, line = 9'd10;
  logic [3:0] acc_type;
  logic       ack;
  logic [1:0] phase;
  int         checks = 0, errors = 0, ack_total = 0, base = 0;

  vdp18_spr_sched dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .clk_en_5m37_i(en5),
    .clk_en_acc_i (acc),
    .num_pix_i    (pix),
    .num_line_i   (line),
    .vert_inc_i   (vert),
    .reg_blank_i  (blank),
    .reg_size1_i  (size1),
    .bg_slot_i    (bg),
    .stop_sprite_i(stop),
    .cpu_req_i    (req),
    .access_type_o(acc_type),
    .cpu_ack_o    (ack),
    .spr_phase_o  (phase)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ack === 1'b1) ack_total++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic enter(input bit is_read, input bit stopv);
    en5 = 1'b1; pix = is_read ? 9'd247 : 9'd0; acc = 1'b1; stop = stopv;
    tick();
    en5 = 1'b0; pix = 9'd100; acc = 1'b0; stop = 1'b0;
  endtask

  task automatic pulse_acc(input bit bgv, input bit stopv);
    bg = bgv; stop = stopv; acc = 1'b1;
    tick();
    acc = 1'b0; bg = 1'b0; stop = 1'b0;
    tick();
  endtask

  task automatic go_idle();
    vert = 1'b1;
    tick();
    vert = 1'b0;
    tick();
  endtask

  // Intended list: TEST = STST,spare,STST,...; READ = SATY..SPTH(,SPTL) per sprite.
  task automatic run_phase(input bit is_read, input int stop_k, input bit reqv, input bit s1,
                           input int bg_pct, input int bg_at);
    logic [3:0] lst[$];
    logic [3:0] cur, nxt;
    logic [1:0] ph;
    int n, p, extra, guard, exp_acks;
    bit cur_last, done, bgv;
    req = 1'b0;
    go_idle();
    req = reqv; size1 = s1; base = ack_total;
    lst = {};
    if (!is_read) begin
      n = (stop_k > 0) ? stop_k : 32;
      for (int i = 0; i < n; i++) begin
        if (i > 0) lst.push_back(reqv ? CPU : NONE);
        lst.push_back(STST);
      end
    end else begin
      n = (stop_k > 0) ? stop_k : 4;
      for (int i = 0; i < n; i++) begin
        lst.push_back(SATY); lst.push_back(SATX); lst.push_back(SATN);
        lst.push_back(SATC); lst.push_back(SPTH);
        if (s1) lst.push_back(SPTL);
      end
    end
    ph = is_read ? 2'd2 : 2'd1;
    enter(is_read, 1'b0);
    chk("entry_phase", 32'(phase), 32'(ph));
    cur = lst[0]; p = 1; cur_last = (lst.size() == 1); done = 1'b0;
    exp_acks = 0; extra = 0; guard = 0;
    while (extra < 3 && guard < 300) begin
      guard++;
      tick();
      chk("slot", 32'(acc_type), 32'(cur));
      bgv = (guard - 1 == bg_at) || (int'($urandom_range(99)) < bg_pct);
      bg = bgv; stop = cur_last && (stop_k > 0); acc = 1'b1;
      tick();
      acc = 1'b0; bg = 1'b0; stop = 1'b0;
      if (cur == CPU) exp_acks++;
      if (cur_last) done = 1'b1;
      if (done) extra++;
      cur_last = 1'b0;
      if (bgv) nxt = NONE;
      else if (p < lst.size()) begin
        nxt = lst[p];
        p++;
        cur_last = (p == lst.size());
      end else nxt = reqv ? CPU : NONE;
      cur = nxt;
      chk("phase", 32'(phase), done ? 32'd0 : 32'(ph));
    end
    chk("bounded", 32'(guard < 300), 32'd1);
    tick(); tick();
    chk("acks", 32'(ack_total - base), 32'(exp_acks));
    req = 1'b0;
  endtask

  initial begin
    bit r, s;
    int k;
    tick(); tick();
    chk("rst_access", 32'(acc_type), 32'(NONE));
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    rst_n = 1'b1;
    tick();

    run_phase(1'b0, 3, 1'b1, 1'b0, 0, -1);  // stop on 3rd STST
    run_phase(1'b0, 0, 1'b1, 1'b0, 0, -1);  // 32 STST cap
    run_phase(1'b1, 2, 1'b0, 1'b0, 0, -1);  // 8x8, stop on 2nd SPTH
    run_phase(1'b1, 0, 1'b0, 1'b1, 0, -1);  // 16x16, 4 sprite cap
    run_phase(1'b1, 0, 1'b0, 1'b0, 0, 1);   // yield the slot after SATX
    for (int i = 0; i < 6; i++) begin
      r = 1'($urandom_range(1));
      s = 1'($urandom_range(1));
      k = r ? int'($urandom_range(4)) : int'($urandom_range(32));
      run_phase(r, k, 1'($urandom_range(1)), s, 25, -1);
    end

    // Line advance during SATC.
    go_idle();
    enter(1'b1, 1'b0);
    pulse_acc(1'b0, 1'b0); pulse_acc(1'b0, 1'b0); pulse_acc(1'b0, 1'b0);
    chk("pre_vert", 32'(acc_type), 32'(SATC));
    vert = 1'b1; tick(); vert = 1'b0;
    chk("vert_access", 32'(acc_type), 32'(NONE));
    chk("vert_phase", 32'(phase), 32'd0);

    // Line advance on the strobe ending a CPU slot still acks exactly once.
    req = 1'b1;
    enter(1'b0, 1'b0);
    pulse_acc(1'b0, 1'b0);
    chk("spare_cpu", 32'(acc_type), 32'(CPU));
    base = ack_total;
    vert = 1'b1; acc = 1'b1; tick(); vert = 1'b0; acc = 1'b0;
    tick(); tick();
    chk("vert_ack", 32'(ack_total - base), 32'd1);
    chk("vert_acc_access", 32'(acc_type), 32'(NONE));

    // Request dropped mid-slot: slot still completes.
    pulse_acc(1'b0, 1'b0);
    chk("idle_cpu", 32'(acc_type), 32'(CPU));
    req = 1'b0; base = ack_total;
    pulse_acc(1'b0, 1'b0); tick();
    chk("drop_ack", 32'(ack_total - base), 32'd1);
    chk("drop_access", 32'(acc_type), 32'(NONE));

    // Asynchronous reset mid-TEST.
    req = 1'b1;
    enter(1'b0, 1'b0);
    pulse_acc(1'b0, 1'b0);
    base = ack_total;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_access", 32'(acc_type), 32'(NONE));
    chk("arst_phase", 32'(phase), 32'd0);
    tick(); rst_n = 1'b1; tick();
    chk("arst_ack", 32'(ack_total - base), 32'd0);
    en5 = 1'b1; pix = 9'd50; tick(); en5 = 1'b0; pix = 9'd100;
    chk("arst_stay_idle", 32'(phase), 32'd0);
    pulse_acc(1'b0, 1'b0);
    chk("arst_idle_slot", 32'(acc_type), 32'(CPU));

    // Blank aborts READ at the next strobe only.
    go_idle();
    enter(1'b1, 1'b0);
    pulse_acc(1'b0, 1'b0);
    blank = 1'b1; tick();
    chk("blank_wait", 32'(phase), 32'd2);
    pulse_acc(1'b0, 1'b0);
    chk("blank_phase", 32'(phase), 32'd0);
    chk("blank_slot", 32'(acc_type), 32'(CPU));
    enter(1'b0, 1'b0);
    chk("blank_no_entry", 32'(phase), 32'd0);
    blank = 1'b0;

    // Line window and stop gating of phase entry.
    line = 9'd200; enter(1'b0, 1'b0);
    chk("line_200", 32'(phase), 32'd0);
    line = 9'h1FF; enter(1'b0, 1'b0);
    chk("line_neg", 32'(phase), 32'd0);
    line = 9'd191; enter(1'b0, 1'b0);
    chk("line_191", 32'(phase), 32'd1);
    line = 9'd10;
    go_idle();
    enter(1'b1, 1'b1);
    chk("stop_blocks_read", 32'(phase), 32'd0);

    // READ taken over from TEST.
    go_idle();
    enter(1'b0, 1'b0);
    pulse_acc(1'b0, 1'b0); pulse_acc(1'b0, 1'b0);
    enter(1'b1, 1'b0);
    chk("test_to_read", 32'(phase), 32'd2);
    chk("test_to_read_slot", 32'(acc_type), 32'(SATY));
    req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
